// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, request record and lane-merge mask for the pipelined data memory
package dmem_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int LANE_W_DEF = 32;
    localparam int DEPTH_DEF  = 64;
    localparam int RD_LAT_DEF = 2;

    localparam int LANES      = LINE_W_DEF / LANE_W_DEF;
    localparam int LANE_SEL_W = $clog2(LANES);
    localparam int LINE_IDX_W = $clog2(DEPTH_DEF);
    localparam int ADDR_W     = LINE_IDX_W + LANE_SEL_W;
    localparam int QDEPTH     = RD_LAT_DEF + 1;

    // Wide enough for any legal line width; callers cast down to their own LINE_W.
    localparam int MASK_MAX_W = 1024;

    typedef struct packed {
        logic                  we;
        logic                  full;
        logic [ADDR_W-1:0]     addr;
        logic [LINE_W_DEF-1:0] wdata;
    } dmem_req_t;

    function automatic logic [MASK_MAX_W-1:0] lane_mask(
        input logic        full,
        input int unsigned sel,
        input int unsigned lane_w
    );
        logic [MASK_MAX_W-1:0] ones;
        ones = (MASK_MAX_W'(1) << lane_w) - MASK_MAX_W'(1);
        return full ? '1 : (ones << (sel * lane_w));
    endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// rtl/dmem_resp_fifo.sv - response queue with occupancy count, push and pop allowed together when full or empty
module dmem_resp_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Empty queue presents zero so the output is defined straight out of reset.
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - lane-addressable data memory with fixed read latency and credit-limited response queue
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter  int LINE_W = LINE_W_DEF,
    parameter  int LANE_W = LANE_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int RD_LAT = RD_LAT_DEF,
    localparam int SEL_W  = $clog2(LINE_W / LANE_W),
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int AW     = IDX_W + SEL_W
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_full,
    input  logic [AW-1:0]     req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_data
);

    localparam int QD = RD_LAT + 1;
    localparam int CW = $clog2(QD + 1);

    logic [LINE_W-1:0] memory [DEPTH];

    logic [IDX_W-1:0]  line;
    logic [SEL_W-1:0]  sel;
    logic              accept;
    logic              rd_accept;
    logic [LINE_W-1:0] wr_mask;
    logic [LINE_W-1:0] wr_data;
    logic [LINE_W-1:0] rd_line;
    logic [LANE_W-1:0] rd_lane;
    logic [LINE_W-1:0] rd_value;
    logic              push;
    logic [LINE_W-1:0] push_data;
    logic              pop;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     credits;

    assign line      = req_addr[AW-1:SEL_W];
    assign sel       = req_addr[SEL_W-1:0];
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;

    assign wr_mask = LINE_W'(lane_mask(req_full, 32'(sel), LANE_W));
    assign wr_data = req_full ? req_wdata
                              : (LINE_W'(req_wdata[LANE_W-1:0]) << (sel * LANE_W));

    always_ff @(posedge clk) begin
        if (accept && req_we)
            memory[line] <= (memory[line] & ~wr_mask) | (wr_data & wr_mask);
    end

    assign rd_line  = memory[line];
    assign rd_lane  = LANE_W'(rd_line >> (sel * LANE_W));
    assign rd_value = req_full ? rd_line : LINE_W'(rd_lane);

    // The queue write is the last latency stage, so only RD_LAT-1 registers sit in front of it.
    generate
        if (RD_LAT == 1) begin : g_direct
            assign push      = rd_accept;
            assign push_data = rd_value;
        end else begin : g_pipe
            logic [RD_LAT-2:0] pv;
            logic [LINE_W-1:0] pd [RD_LAT-1];

            always_ff @(posedge clk or posedge RESET) begin
                if (RESET) begin
                    pv <= '0;
                    for (int i = 0; i < RD_LAT - 1; i++) pd[i] <= '0;
                end else begin
                    pv[0] <= rd_accept;
                    pd[0] <= rd_value;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign push      = pv[RD_LAT-2];
            assign push_data = pd[RD_LAT-2];
        end
    endgenerate

    dmem_resp_fifo #(
        .WIDTH (LINE_W),
        .DEPTH (QD)
    ) u_fifo (
        .clk       (clk),
        .RESET     (RESET),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (resp_data),
        .count     (q_count)
    );

    assign resp_valid = (q_count != '0);
    assign pop        = resp_valid && resp_ready;

    // One credit per queue slot; a read holds its credit from accept until its response is taken.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET)                  credits <= CW'(QD);
        else if (rd_accept && !pop) credits <= credits - CW'(1);
        else if (pop && !rd_accept) credits <= credits + CW'(1);
    end

    assign req_ready = (credits != '0);

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, pipelined data memory for the pipelined core. It replaces the single-cycle, fixed 128-bit data memory used by the unpipelined core. The block adds lane-granular (sub-line) access, a configurable read latency, and a valid/ready request/response handshake with credit-based back-pressure. It sits between the MEM stage and the line-wide data array, which the bench preloads through the hierarchical array `memory`.

## Interface
- LINE_W, 128: data line width in bits.
- LANE_W, 32: lane width in bits; LINE_W must be a multiple of LANE_W.
- DEPTH, 64: number of lines; must be a power of two.
- RD_LAT, 2: cycles from read accept to first possible resp_valid; legal range 1..4.
- clk  in  1: single clock, rising edge.
- RESET  in  1: asynchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request.
- req_we  in  1: 1 = write, 0 = read.
- req_full  in  1: 1 = whole-line access, 0 = single-lane access.
- req_addr  in  ADDR_W: {line index, lane select}. ADDR_W = log2(DEPTH) + log2(LINE_W/LANE_W).
- req_wdata  in  LINE_W: write data. Lane writes use bits [LANE_W-1:0].
- resp_valid  out  1: read data present.
- resp_ready  in  1: consumer takes the response.
- resp_data  out  LINE_W: line data, or a zero-extended lane in bits [LANE_W-1:0].

## Operation
- A request is accepted on any rising edge where req_valid && req_ready.
- Write, full-line: memory[line] <= req_wdata on the accept edge.
- Write, lane: only lane `sel` of memory[line] is updated, at bits [sel*LANE_W +: LANE_W]. The other lanes are unchanged.
- Writes produce no response and consume no credit.
- Read: the array is sampled on the accept edge, and the value then travels through an RD_LAT-stage pipeline into the response queue.
- A read accepted in the cycle after a write to the same line returns the written data. A read and a write cannot be accepted in the same cycle because there is a single request port.
- Lane read: resp_data = {zeros, lane}. Full read: the whole line.
- Response queue: FIFO with QDEPTH = RD_LAT+1 entries; resp_valid = queue not empty.
- Credits:
  - The counter resets to QDEPTH.
  - An accepted read decrements it.
  - A resp handshake (resp_valid && resp_ready) increments it.
  - If both happen in the same cycle, the counter is unchanged.
- req_ready = (credits != 0), independent of req_we. Because of this the queue never overflows.
- Responses are returned strictly in acceptance order.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, credits=QDEPTH, all pipeline valids=0, queue empty.
- Memory contents are not touched by RESET.
- A read accepted at edge T with resp_ready held high gives resp_valid=1 in the cycle after edge T+RD_LAT-1, i.e. exactly RD_LAT cycles later.
- Back-to-back reads sustain 1 response/cycle while resp_ready=1.
- While resp_valid && !resp_ready, resp_data and resp_valid are held stable.
- With resp_ready held low, exactly QDEPTH reads are accepted; req_ready then drops on the edge after the last accept.
- Credit frees in the cycle after a resp handshake, so req_ready can rise that same cycle.
- RESET asserted mid-operation: in-flight reads and queued responses are discarded immediately (asynchronous clear). Writes already accepted remain in memory.

## Structure
- Package dmem_pkg holds:
  - LANES = LINE_W/LANE_W, LANE_SEL_W, LINE_IDX_W, ADDR_W, QDEPTH;
  - a request struct {we, full, addr, wdata};
  - a function computing the lane-merge write mask.
- Sub-module dmem_resp_fifo: parametrised FIFO (width LINE_W, depth QDEPTH) with count, asynchronous active-high RESET, and simultaneous push/pop supported on full and empty.
- Top level holds: the array `memory`, the read pipeline shift registers with valid bits, lane select/merge logic, and the credit counter.

## Test plan
- Lane read at defaults, with memory[0]=128'haa29df7d196f03aa5e36698ba569b133 preloaded:
  - read lane addr 0 -> resp_data=32'ha569b133 two cycles after accept;
  - read addr 3 -> 32'haa29df7d.
- Lane write then full read: write lane addr 1 with 32'hdeadbeef, then full-read line 0 the next cycle -> 128'haa29df7d196f03aadeadbeefa569b133.
- Back-pressure: hold resp_ready=0 and issue 5 reads to lines 0..4 -> exactly 3 accepted, req_ready=0. Then release resp_ready -> responses arrive in order 0,1,2, and the remaining reads complete in order.
- Throughput: 8 back-to-back full reads with resp_ready=1 -> 8 consecutive resp_valid cycles, first at accept+RD_LAT; repeat with RD_LAT=1 and RD_LAT=4.
- Reset mid-flight: 2 reads in flight, then pulse RESET for a half cycle -> resp_valid=0 and req_ready=1 immediately. A write made before reset persists on the subsequent read.
